tone_synth_poly: RTL and testbench
==================================

// Module: tone_synth_poly
// PURPOSE
//  Polyphonic square-wave tone generator: NUM_VOICES independent voices, each with
//  a runtime half-period. Voice outputs are summed, saturated and handed to the
//  audio controller as a stereo sample, paced by the controller's sample handshake.
//  It sits between the note-select logic (game/SW decode) and the audio controller.
// PARAMETERS
//  NUM_VOICES   3             number of voices (1..8)
//  DIV_W        19            width of each half-period field, in CLOCK_50 cycles
//  SAMPLE_W     32            signed output sample width
//  AMP          32'h2A000000  per-voice peak amplitude (positive, < 2^(SAMPLE_W-1))
//  DECAY_SHIFT  4             decay step = amp >> DECAY_SHIFT (DECAY_EN only)
//  DECAY_DIV    256           samples written between decay steps (DECAY_EN only)
// PORTS
//  CLOCK_50          in   1                    system clock
//  resetn            in   1                    asynchronous reset, active-low
//  voice_en          in   NUM_VOICES           per-voice enable
//  half_period       in   NUM_VOICES*DIV_W     voice i at [i*DIV_W +: DIV_W]
//  audio_in_available in  1                    controller sample tick (pacing)
//  audio_out_allowed in   1                    controller output FIFO has space
//  read_audio_in     out  1                    drains the input FIFO
//  write_audio_out   out  1                    one-cycle write strobe
//  left_channel_audio_out  out SAMPLE_W        signed sample
//  right_channel_audio_out out SAMPLE_W        identical to left
// BEHAVIOUR
//  - Reset: all counters 0, all phases 0, samples 0, write_audio_out 0.
//  - Voice i enabled with hp = half_period_i != 0: counter increments every cycle;
//    when counter >= hp-1, counter <= 0 and phase toggles (period = 2*hp cycles).
//    Using >= makes a mid-count decrease of hp take effect on the next cycle.
//  - hp == 0 or voice disabled: counter and phase held at 0; contribution 0.
//  - Contribution: phase 1 -> +amp_i, phase 0 -> -amp_i (amp_i = AMP unless DECAY_EN).
//  - Mix: signed sum at SAMPLE_W+3 bits; saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
//  - read_audio_in = audio_in_available & audio_out_allowed (combinational).
//  - Write: when audio_in_available & audio_out_allowed & |voice_en are all high in
//    cycle N, the mix is registered into both sample outputs and write_audio_out = 1
//    in cycle N+1 (data and strobe aligned, latency 1). Otherwise strobe is 0 and
//    samples hold. No write is issued when all voices are disabled.
//  - Toggle and write in the same cycle: the sample uses the pre-toggle phase.
//  - Reset mid-operation: immediate clear, regardless of whether a strobe is pending.
// CONFIGURATION
//  TONE_SYNTH_DECAY_EN defined: each voice has an amplitude register amp_i, loaded
//   with AMP on the voice_en rising edge (and at reset: 0). A sample counter
//   increments on each write; at DECAY_DIV writes it wraps and every amp_i
//   <= amp_i - (amp_i >> DECAY_SHIFT), floored at 0 (a value below 2^DECAY_SHIFT
//   is cleared to 0). Disabling a voice clears amp_i. Gives plucked-note decay.
//  Undefined: amp_i is constant AMP; no amplitude registers or sample counter.
// TESTING
//  1. Voice0 en, hp=48, others off -> phase toggles every 48 cycles; period 96.
//  2. Keep audio_in_available=audio_out_allowed=1, voice0 at +phase -> strobe each
//     cycle; sample 0x2A000000; at -phase 0xD6000000; read_audio_in=1.
//  3. All 3 voices en, phases aligned +: sum 0x7E000000 fits; AMP=0x40000000 ->
//     saturates to 0x7FFFFFFF; all negative -> 0x80000000.
//  4. voice_en=0 with pacing high -> write_audio_out stays 0; hp changed 61->20
//     while counter=40 -> toggle on next cycle, then every 20 cycles.
//  5. Assert resetn=0 during strobe cycle -> write_audio_out, samples 0 at once.
//  6. DECAY_EN, DECAY_DIV=4, shift 4: after 4 writes amp = 0x27600000; voice
//     re-enable reloads 0x2A000000.

Source files
------------

// File: rtl/tone_synth_poly.sv
// Polyphonic square-wave tone generator with saturating stereo mix.
// Define TONE_SYNTH_DECAY_EN for per-voice plucked amplitude decay.
module tone_synth_poly #(
  parameter int NUM_VOICES = 3,
  parameter int DIV_W = 19,
  parameter int SAMPLE_W = 32,
  parameter logic [SAMPLE_W-1:0] AMP = 32'h2A000000,
  parameter int DECAY_SHIFT = 4,
  parameter int DECAY_DIV = 256
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic [NUM_VOICES-1:0]       voice_en,
  input  logic [NUM_VOICES*DIV_W-1:0] half_period,
  input  logic                        audio_in_available,
  input  logic                        audio_out_allowed,
  output logic                        read_audio_in,
  output logic                        write_audio_out,
  output logic [SAMPLE_W-1:0]         left_channel_audio_out,
  output logic [SAMPLE_W-1:0]         right_channel_audio_out
);

  localparam int MIX_W = SAMPLE_W + 3;
  localparam logic signed [MIX_W-1:0] SMAX =
    {4'b0000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [MIX_W-1:0] SMIN =
    {4'b1111, {(SAMPLE_W-1){1'b0}}};

  if (NUM_VOICES < 1 || NUM_VOICES > 8 ||
      DECAY_SHIFT < 1 || DECAY_SHIFT >= SAMPLE_W ||
      DECAY_DIV < 1) begin : g_bad_cfg
    $error("tone_synth_poly: parameter out of range");
  end

  logic [DIV_W-1:0]      hp    [NUM_VOICES];
  logic [DIV_W-1:0]      cnt   [NUM_VOICES];
  logic [SAMPLE_W-1:0]   amp   [NUM_VOICES];
  logic [NUM_VOICES-1:0] phase;
  logic [NUM_VOICES-1:0] active;
  logic signed [MIX_W-1:0] mix;
  logic signed [MIX_W-1:0] sat;
  logic                  fire;
  logic [SAMPLE_W-1:0]   sample_q;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      hp[i]     = half_period[i*DIV_W +: DIV_W];
      active[i] = voice_en[i] && (hp[i] != '0);
    end
  end

  assign read_audio_in = audio_in_available & audio_out_allowed;
  assign fire = read_audio_in & (|voice_en);

  // >= rather than == so a shrinking half-period takes effect at once
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_VOICES; i++) cnt[i] <= '0;
      phase <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (!active[i]) begin
          cnt[i]   <= '0;
          phase[i] <= 1'b0;
        end else if (cnt[i] >= hp[i] - DIV_W'(1)) begin
          cnt[i]   <= '0;
          phase[i] <= ~phase[i];
        end else begin
          cnt[i] <= cnt[i] + DIV_W'(1);
        end
      end
    end
  end

`ifdef TONE_SYNTH_DECAY_EN
  localparam int DC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [DC_W-1:0]       dcnt;
  logic [NUM_VOICES-1:0] en_q;
  logic [SAMPLE_W-1:0]   amp_q [NUM_VOICES];
  logic                  dstep;

  assign dstep = fire && (dcnt == DC_W'(DECAY_DIV - 1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      dcnt <= '0;
      en_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) amp_q[i] <= '0;
    end else begin
      en_q <= voice_en;
      if (fire) dcnt <= dstep ? '0 : dcnt + DC_W'(1);
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (!voice_en[i]) begin
          amp_q[i] <= '0;
        end else if (!en_q[i]) begin
          amp_q[i] <= AMP;
        end else if (dstep) begin
          // tiny amplitudes would never shrink, so snap them to silence
          if ((amp_q[i] >> DECAY_SHIFT) == '0) amp_q[i] <= '0;
          else amp_q[i] <= amp_q[i] - (amp_q[i] >> DECAY_SHIFT);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) amp[i] = amp_q[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) amp[i] = AMP;
  end
`endif

  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (active[i]) begin
        if (phase[i]) mix = mix + $signed({3'b000, amp[i]});
        else          mix = mix - $signed({3'b000, amp[i]});
      end
    end
    if (mix > SMAX)      sat = SMAX;
    else if (mix < SMIN) sat = SMIN;
    else                 sat = mix;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sample_q        <= '0;
      write_audio_out <= 1'b0;
    end else begin
      write_audio_out <= fire;
      if (fire) sample_q <= sat[SAMPLE_W-1:0];
    end
  end

  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;

endmodule

// File: tb/tb_tone_synth_poly.sv
// Directed bench for tone_synth_poly: timing, mix, saturation, pacing, reset.
// A second instance with a larger amplitude exercises saturation.
module tb_tone_synth_poly;

  localparam int NV = 3;
  localparam int DW = 19;

  logic          clk;
  logic          resetn;
  logic [NV-1:0] voice_en;
  logic [NV*DW-1:0] half_period;
  logic          avail;
  logic          allowed;
  logic          rd_a, wr_a;
  logic [31:0]   left_a, right_a;
  logic          rd_b, wr_b;
  logic [31:0]   left_b, right_b;

  int checks = 0;
  int errors = 0;

  tone_synth_poly dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .voice_en(voice_en),
    .half_period(half_period),
    .audio_in_available(avail),
    .audio_out_allowed(allowed),
    .read_audio_in(rd_a),
    .write_audio_out(wr_a),
    .left_channel_audio_out(left_a),
    .right_channel_audio_out(right_a)
  );

  tone_synth_poly #(.AMP(32'h40000000)) dut_big (
    .CLOCK_50(clk),
    .resetn(resetn),
    .voice_en(voice_en),
    .half_period(half_period),
    .audio_in_available(avail),
    .audio_out_allowed(allowed),
    .read_audio_in(rd_b),
    .write_audio_out(wr_b),
    .left_channel_audio_out(left_b),
    .right_channel_audio_out(right_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [NV*DW-1:0] hps(input int h2, input int h1,
                                           input int h0);
    return {DW'(h2), DW'(h1), DW'(h0)};
  endfunction

  initial begin
    resetn = 1'b0;
    voice_en = '0;
    half_period = '0;
    avail = 1'b0;
    allowed = 1'b0;
    tick(3);
    chk("rst_wr", 32'(wr_a), 32'd0);
    chk("rst_left", left_a, 32'h0);
    chk("rst_right", right_a, 32'h0);
    chk("rst_rd", 32'(rd_a), 32'd0);
    resetn = 1'b1;
    tick(2);
    chk("idle_wr", 32'(wr_a), 32'd0);

    // voice0, hp=48, pacing high every cycle
    half_period = hps(0, 0, 48);
    voice_en = 3'b001;
    avail = 1'b1;
    allowed = 1'b1;
    #1;
    chk("rd_comb", 32'(rd_a), 32'd1);
    tick(1);
    chk("v0_first_wr", 32'(wr_a), 32'd1);
    chk("v0_first_l", left_a, 32'hD6000000);
    chk("v0_first_r", right_a, 32'hD6000000);
    tick(47);
    chk("v0_e48_pretoggle", left_a, 32'hD6000000);
    tick(1);
    chk("v0_e49_pos", left_a, 32'h2A000000);
    chk("v0_e49_pos_r", right_a, 32'h2A000000);
    chk("v0_e49_wr", 32'(wr_a), 32'd1);
    tick(47);
    chk("v0_e96_pos", left_a, 32'h2A000000);
    tick(1);
    chk("v0_e97_neg", left_a, 32'hD6000000);

    // all voices disabled: no writes, sample holds
    voice_en = '0;
    tick(1);
    chk("off_wr", 32'(wr_a), 32'd0);
    chk("off_hold", left_a, 32'hD6000000);
    tick(3);
    chk("off_wr2", 32'(wr_a), 32'd0);
    chk("off_rd", 32'(rd_a), 32'd1);

    // output FIFO full blocks the write
    voice_en = 3'b001;
    allowed = 1'b0;
    tick(2);
    chk("full_wr", 32'(wr_a), 32'd0);
    chk("full_rd", 32'(rd_a), 32'd0);
    chk("full_hold", left_a, 32'hD6000000);

    // clear, then shrink hp 61->20 while counter is 40
    voice_en = '0;
    allowed = 1'b1;
    tick(1);
    half_period = hps(0, 0, 61);
    voice_en = 3'b001;
    tick(40);
    chk("hp61_e40", left_a, 32'hD6000000);
    half_period = hps(0, 0, 20);
    tick(1);
    chk("hp20_e41", left_a, 32'hD6000000);
    tick(1);
    chk("hp20_e42", left_a, 32'h2A000000);
    tick(19);
    chk("hp20_e61", left_a, 32'h2A000000);
    tick(1);
    chk("hp20_e62", left_a, 32'hD6000000);

    // three aligned voices, and saturation in the big-amp instance
    voice_en = '0;
    tick(1);
    half_period = hps(10, 10, 10);
    voice_en = 3'b111;
    tick(1);
    chk("mix3_neg", left_a, 32'h82000000);
    chk("sat_neg", left_b, 32'h80000000);
    chk("sat_neg_r", right_b, 32'h80000000);
    chk("sat_neg_wr", 32'(wr_b), 32'd1);
    tick(10);
    chk("mix3_pos", left_a, 32'h7E000000);
    chk("mix3_pos_r", right_a, 32'h7E000000);
    chk("sat_pos", left_b, 32'h7FFFFFFF);

    // an enabled voice with hp=0 contributes nothing
    voice_en = '0;
    tick(1);
    half_period = hps(0, 10, 10);
    voice_en = 3'b111;
    tick(1);
    chk("hp0_mix", left_a, 32'hAC000000);
    chk("hp0_big", left_b, 32'h80000000);
    tick(10);
    chk("hp0_mix_pos", left_a, 32'h54000000);
    chk("hp0_big_pos", left_b, 32'h7FFFFFFF);

    // async reset during a strobe cycle
    chk("pre_rst_wr", 32'(wr_a), 32'd1);
    resetn = 1'b0;
    #1;
    chk("arst_wr", 32'(wr_a), 32'd0);
    chk("arst_left", left_a, 32'h0);
    chk("arst_right", right_a, 32'h0);
    chk("arst_big", left_b, 32'h0);
    tick(1);
    resetn = 1'b1;
    tick(1);
    chk("post_rst", left_a, 32'hAC000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
